// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences a 1-bit full adder over WIDTH bits, LSB first
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0] cnt;
    logic carry, fa_s, fa_c;

    // the single full-adder cell working on the current bit position
    always_comb begin
        fa_s = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    // control FSM, operand/sum shifters and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    carry  <= cin;
                    cnt    <= '0;
                    sum_sh <= '0;
                    ready  <= 1'b0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // the carry register here is the carry into the MSB
                        sum   <= {fa_s, sum_sh[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks against an a+b+cin model
module tb_serial_adder_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0, sum;
    logic ready, busy, done, cout, ovf;
    int checks = 0, failures = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: 9-bit sum for cout, sign rule for overflow
    task automatic model(input logic [7:0] x, input logic [7:0] y, input logic c,
                         output logic [7:0] s, output logic co, output logic v);
        logic [8:0] t;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
        s = t[7:0];
        co = t[8];
        v = (x[7] == y[7]) && (s[7] != x[7]);
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, input string tag);
        int n;
        logic [7:0] es;
        logic ec, ev;
        model(ta, tbv, tc, es, ec, ev);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        chk({tag, ".ready_pre"}, ready, 1);
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        chk({tag, ".busy"}, {ready, busy}, 2'b01);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 9);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, ev);
        @(negedge clk);
        chk({tag, ".after"}, {done, ready, busy}, 3'b010);
    endtask

    initial begin
        logic [16:0] q[$];
        int acc[$];
        int nd;
        logic [7:0] es;
        logic ec, ev;
        repeat (2) @(negedge clk);
        chk("reset", {ready, busy, done, sum, cout, ovf}, {3'b100, 8'h00, 2'b00});
        rst_n = 1'b1;

        do_op(8'h00, 8'h00, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, "ff_01");
        do_op(8'h7F, 8'h01, 1'b0, "7f_01");
        do_op(8'h80, 8'h80, 1'b1, "80_80_c");
        do_op(8'hFF, 8'hFF, 1'b1, "ff_ff_c");
        for (int i = 0; i < 1500; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");

        // start while busy is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                nd++;
                chk("ignore.sum", sum, 8'h46);
            end
            @(negedge clk);
        end
        chk("ignore.ndone", nd, 1);
        chk("ignore.hold_idle", sum, 8'h46);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignore.hold_run", sum, 8'h46);
        repeat (10) @(negedge clk);

        // reset with counter at 4
        do_op(8'h5A, 8'h3C, 1'b1, "pre_rst");
        @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.outs", {ready, busy, done, sum, cout, ovf}, {3'b100, 8'h00, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("midrst.nodone", nd, 0);
        chk("midrst.ready", ready, 1);

        // continuous start: back-to-back with fresh operands every cycle
        start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            if (done === 1'b1) begin
                if (q.size() == 0) chk("cont.spurious_done", 1, 0);
                else begin
                    model(q[0][16:9], q[0][8:1], q[0][0], es, ec, ev);
                    void'(q.pop_front());
                    chk("cont.result", {sum, cout, ovf}, {es, ec, ev});
                end
            end
            if (ready === 1'b1) begin
                q.push_back({a, b, cin});
                acc.push_back(c);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("cont.accepts", acc.size(), 5);
        for (int i = 1; i < acc.size(); i++)
            chk("cont.gap", acc[i] - acc[i-1], 10);
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
